// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle MDU stalls and
// redirect flushes, with a saturating counter of cycles where the PC is held.
module hazard_ctrl #(
  parameter int MEM_LAT     = 1,
  parameter int MDU_LAT     = 8,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_mdu_start,
  input  logic             Branch,
  input  logic             condition,
  input  logic             is_jump,
  output logic             control_flush,
  output logic             instrution_flush,
  output logic             pc_we,
  output logic             IFID_we,
  output logic             IDEX_we,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       dbg_state
);

  localparam int MAX_LAT = (MEM_LAT > MDU_LAT) ? MEM_LAT : MDU_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    MEM_INIT  = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0]    MDU_INIT  = CW'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    LOAD_STALL = 2'd1,
    MDU_BUSY   = 2'd2,
    FLUSH      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic load_hit, redirect;
  logic cf_c, if_c, pc_we_c, ifid_we_c, idex_we_c;

  assign load_hit = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                    ((rs1_used && (rs1 == IDEX_rd)) || (rs2_used && (rs2 == IDEX_rd)));
  assign redirect = is_jump || (Branch && condition);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cf_c      = 1'b0;
    if_c      = 1'b0;
    pc_we_c   = 1'b1;
    ifid_we_c = 1'b1;
    idex_we_c = 1'b1;
    unique case (state_q)
      NORMAL: begin
        if (IDEX_mdu_start) begin
          pc_we_c   = 1'b0;
          ifid_we_c = 1'b0;
          if (MDU_LAT > 1) begin
            state_d = MDU_BUSY;
            cnt_d   = MDU_INIT;
          end
        end else if (load_hit) begin
          cf_c      = 1'b1;
          pc_we_c   = 1'b0;
          ifid_we_c = 1'b0;
          if (MEM_LAT > 1) begin
            state_d = LOAD_STALL;
            cnt_d   = MEM_INIT;
          end
        end else if (redirect) begin
          cf_c      = 1'b1;
          if_c      = 1'b1;
          ifid_we_c = 1'b0;
          if (FLUSH_DEPTH == 2) state_d = FLUSH;
        end
      end
      // Hazard inputs are deliberately ignored until the stall drains.
      LOAD_STALL: begin
        cf_c      = 1'b1;
        pc_we_c   = 1'b0;
        ifid_we_c = 1'b0;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = NORMAL;
      end
      MDU_BUSY: begin
        pc_we_c   = 1'b0;
        ifid_we_c = 1'b0;
        idex_we_c = 1'b0;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = NORMAL;
      end
      FLUSH: begin
        if_c      = 1'b1;
        ifid_we_c = 1'b0;
        state_d   = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  // Outputs are forced to a safe freeze-and-flush pattern while in reset.
  always_comb begin
    control_flush    = rstn ? cf_c      : 1'b1;
    instrution_flush = rstn ? if_c      : 1'b1;
    pc_we            = rstn ? pc_we_c   : 1'b0;
    IFID_we          = rstn ? ifid_we_c : 1'b0;
    IDEX_we          = rstn ? idex_we_c : 1'b0;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_we && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + STALL_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= NORMAL;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign busy        = (state_q != NORMAL);
  assign stall_count = stall_count_q;
  assign dbg_state   = state_q;

endmodule
